// File: rtl/lc_arbiter_if.sv
`default_nettype none
// ============================================================================
// lc_arbiter_if -- L1I/L1D request, line-fill and backing-memory bundle
// Rev 1.0
// ============================================================================
interface lc_arbiter_if #(
  parameter int CACHE_LINE_BYTES = 64,
  parameter int ADDR_WIDTH       = 64
);
  localparam int LINE_BITS = CACHE_LINE_BYTES * 8;

  logic                  l1i_req_valid_in;
  logic                  l1i_req_ready_out;
  logic [ADDR_WIDTH-1:0] l1i_req_addr_in;
  logic                  l1i_lc_valid_out;
  logic                  l1i_lc_ready_in;
  logic [ADDR_WIDTH-1:0] l1i_lc_addr_out;
  logic [LINE_BITS-1:0]  l1i_lc_value_out;

  logic                  l1d_req_valid_in;
  logic                  l1d_req_ready_out;
  logic [ADDR_WIDTH-1:0] l1d_req_addr_in;
  logic                  l1d_req_we_in;
  logic [LINE_BITS-1:0]  l1d_req_data_in;
  logic                  l1d_lc_valid_out;
  logic                  l1d_lc_ready_in;
  logic [ADDR_WIDTH-1:0] l1d_lc_addr_out;
  logic [LINE_BITS-1:0]  l1d_lc_value_out;

  logic                  mem_req_valid_out;
  logic                  mem_req_ready_in;
  logic [ADDR_WIDTH-1:0] mem_req_addr_out;
  logic                  mem_req_we_out;
  logic [LINE_BITS-1:0]  mem_req_data_out;
  logic                  mem_resp_valid_in;
  logic [LINE_BITS-1:0]  mem_resp_data_in;

  // Arbiter side
  modport slave (
    input  l1i_req_valid_in, l1i_req_addr_in, l1i_lc_ready_in,
    output l1i_req_ready_out, l1i_lc_valid_out, l1i_lc_addr_out, l1i_lc_value_out,
    input  l1d_req_valid_in, l1d_req_addr_in, l1d_req_we_in, l1d_req_data_in, l1d_lc_ready_in,
    output l1d_req_ready_out, l1d_lc_valid_out, l1d_lc_addr_out, l1d_lc_value_out,
    input  mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
    output mem_req_valid_out, mem_req_addr_out, mem_req_we_out, mem_req_data_out
  );

  // Cache and memory side
  modport master (
    output l1i_req_valid_in, l1i_req_addr_in, l1i_lc_ready_in,
    input  l1i_req_ready_out, l1i_lc_valid_out, l1i_lc_addr_out, l1i_lc_value_out,
    output l1d_req_valid_in, l1d_req_addr_in, l1d_req_we_in, l1d_req_data_in, l1d_lc_ready_in,
    input  l1d_req_ready_out, l1d_lc_valid_out, l1d_lc_addr_out, l1d_lc_value_out,
    output mem_req_ready_in, mem_resp_valid_in, mem_resp_data_in,
    input  mem_req_valid_out, mem_req_addr_out, mem_req_we_out, mem_req_data_out
  );
endinterface
`default_nettype wire

// File: rtl/lc_arbiter.sv
`default_nettype none
// ============================================================================
// lc_arbiter -- round-robin L1I/L1D miss arbiter, one outstanding line txn
// Rev 1.0
// ============================================================================
module lc_arbiter #(
  parameter int CACHE_LINE_BYTES = 64,
  parameter int ADDR_WIDTH       = 64
) (
  input  wire logic   clk_in,
  input  wire logic   rst_N_in,
  lc_arbiter_if.slave bus
);
  localparam int                    LINE_BITS = CACHE_LINE_BYTES * 8;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(CACHE_LINE_BYTES - 1);
  localparam logic                  SRC_L1I   = 1'b0;
  localparam logic                  SRC_L1D   = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_src;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_BITS-1:0]  r_data;

  logic                  w_grant_i;
  logic                  w_grant_d;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] w_req_addr;

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt           = r_state;
    w_grant_i             = 1'b0;
    w_grant_d             = 1'b0;
    bus.l1i_req_ready_out = 1'b0;
    bus.l1d_req_ready_out = 1'b0;
    bus.l1i_lc_valid_out  = 1'b0;
    bus.l1d_lc_valid_out  = 1'b0;
    bus.mem_req_valid_out = 1'b0;
    case (r_state)
      IDLE: begin
        // r_src holds the last winner; under contention the other source wins
        if (rst_N_in) begin
          w_grant_d = bus.l1d_req_valid_in && (!bus.l1i_req_valid_in || (r_src == SRC_L1I));
          w_grant_i = bus.l1i_req_valid_in && !w_grant_d;
        end
        bus.l1i_req_ready_out = w_grant_i;
        bus.l1d_req_ready_out = w_grant_d;
        if (w_grant_i || w_grant_d) begin
          w_state_nxt = MEM_REQ;
        end
      end
      MEM_REQ: begin
        bus.mem_req_valid_out = 1'b1;
        if (bus.mem_req_ready_in) begin
          w_state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_resp_valid_in) begin
          w_state_nxt = r_we ? IDLE : RESP;
        end
      end
      RESP: begin
        if (r_src == SRC_L1D) begin
          bus.l1d_lc_valid_out = 1'b1;
          if (bus.l1d_lc_ready_in) begin
            w_state_nxt = IDLE;
          end
        end else begin
          bus.l1i_lc_valid_out = 1'b1;
          if (bus.l1i_lc_ready_in) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept   = w_grant_i || w_grant_d;
  assign w_req_addr = w_grant_d ? bus.l1d_req_addr_in : bus.l1i_req_addr_in;

  always_ff @(posedge clk_in) begin
    if (!rst_N_in) begin
      r_src  <= SRC_L1I;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      if (w_accept) begin
        r_src  <= w_grant_d ? SRC_L1D : SRC_L1I;
        r_we   <= w_grant_d && bus.l1d_req_we_in;
        r_addr <= w_req_addr & LINE_MASK;
        r_data <= w_grant_d ? bus.l1d_req_data_in : '0;
      end
      // Response data replaces the writeback payload; only fills consume it
      if ((r_state == MEM_WAIT) && bus.mem_resp_valid_in) begin
        r_data <= bus.mem_resp_data_in;
      end
    end
  end

  assign bus.mem_req_addr_out = r_addr;
  assign bus.mem_req_we_out   = r_we;
  assign bus.mem_req_data_out = r_data;
  assign bus.l1i_lc_addr_out  = r_addr;
  assign bus.l1i_lc_value_out = r_data;
  assign bus.l1d_lc_addr_out  = r_addr;
  assign bus.l1d_lc_value_out = r_data;
endmodule
`default_nettype wire

// File: tb/tb_lc_arbiter.sv
`default_nettype none
// ============================================================================
// tb_lc_arbiter -- directed and randomized self-checking bench for lc_arbiter
// Rev 1.0
// ============================================================================
module tb_lc_arbiter;
  localparam int LB = 64;
  localparam int AW = 64;
  localparam int DW = LB * 8;
  localparam logic [AW-1:0] ALIGN = ~64'h3F;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  lc_arbiter_if #(.CACHE_LINE_BYTES(LB), .ADDR_WIDTH(AW)) bus ();
  lc_arbiter #(.CACHE_LINE_BYTES(LB), .ADDR_WIDTH(AW)) dut (
    .clk_in   (clk),
    .rst_N_in (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.l1i_req_valid_in = 1'b0; bus.l1i_req_addr_in = '0; bus.l1i_lc_ready_in = 1'b0;
    bus.l1d_req_valid_in = 1'b0; bus.l1d_req_addr_in = '0; bus.l1d_req_we_in = 1'b0;
    bus.l1d_req_data_in  = '0;   bus.l1d_lc_ready_in = 1'b0;
    bus.mem_req_ready_in = 1'b0; bus.mem_resp_valid_in = 1'b0; bus.mem_resp_data_in = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); rst_n = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.l1i_req_valid_in = 1'b1; bus.l1d_req_valid_in = 1'b1; bus.mem_resp_valid_in = 1'b1;
    bus.mem_req_ready_in = 1'b1;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    n_cmp++; if (bus.l1i_req_ready_out !== 1'b0) begin n_err++; $display("FAIL rst_l1i_ready: got %b want 0", bus.l1i_req_ready_out); end
    n_cmp++; if (bus.l1d_req_ready_out !== 1'b0) begin n_err++; $display("FAIL rst_l1d_ready: got %b want 0", bus.l1d_req_ready_out); end
    n_cmp++; if (bus.mem_req_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_mem_valid: got %b want 0", bus.mem_req_valid_out); end
    n_cmp++; if (bus.l1i_lc_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_l1i_lc_valid: got %b want 0", bus.l1i_lc_valid_out); end
    n_cmp++; if (bus.l1d_lc_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_l1d_lc_valid: got %b want 0", bus.l1d_lc_valid_out); end
    n_cmp++; if (bus.mem_req_addr_out !== '0) begin n_err++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_req_addr_out); end
    n_cmp++; if (bus.mem_req_we_out !== 1'b0) begin n_err++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_req_we_out); end
    n_cmp++; if (bus.mem_req_data_out !== '0) begin n_err++; $display("FAIL rst_mem_data: got %h want 0", bus.mem_req_data_out); end
    n_cmp++; if (bus.l1i_lc_addr_out !== '0) begin n_err++; $display("FAIL rst_l1i_lc_addr: got %h want 0", bus.l1i_lc_addr_out); end
    n_cmp++; if (bus.l1d_lc_value_out !== '0) begin n_err++; $display("FAIL rst_l1d_lc_value: got %h want 0", bus.l1d_lc_value_out); end
    idle_inputs(); rst_n = 1'b1;
  endtask

  task automatic test_l1i_read();
    logic [DW-1:0] d1;
    d1 = rand_line();
    do_reset();
    @(negedge clk); bus.l1i_req_valid_in = 1'b1; bus.l1i_req_addr_in = 64'h47; #1;
    n_cmp++; if (bus.l1i_req_ready_out !== 1'b1) begin n_err++; $display("FAIL rd_l1i_ready: got %b want 1", bus.l1i_req_ready_out); end
    @(negedge clk); bus.l1i_req_valid_in = 1'b0; bus.mem_req_ready_in = 1'b1; #1;
    n_cmp++; if (bus.mem_req_valid_out !== 1'b1) begin n_err++; $display("FAIL rd_mem_valid: got %b want 1", bus.mem_req_valid_out); end
    n_cmp++; if (bus.mem_req_addr_out !== 64'h40) begin n_err++; $display("FAIL rd_mem_addr: got %h want 40", bus.mem_req_addr_out); end
    n_cmp++; if (bus.mem_req_we_out !== 1'b0) begin n_err++; $display("FAIL rd_mem_we: got %b want 0", bus.mem_req_we_out); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); bus.mem_req_ready_in = 1'b0; #1;
      n_cmp++; if (bus.l1i_lc_valid_out !== 1'b0 || bus.mem_req_valid_out !== 1'b0) begin n_err++; $display("FAIL rd_wait_quiet: got lc=%b mem=%b want 0 0", bus.l1i_lc_valid_out, bus.mem_req_valid_out); end
    end
    @(negedge clk); bus.mem_resp_valid_in = 1'b1; bus.mem_resp_data_in = d1;
    @(negedge clk); bus.mem_resp_valid_in = 1'b0; bus.mem_resp_data_in = '0; #1;
    n_cmp++; if (bus.l1i_lc_valid_out !== 1'b1) begin n_err++; $display("FAIL rd_fill_valid: got %b want 1", bus.l1i_lc_valid_out); end
    n_cmp++; if (bus.l1i_lc_addr_out !== 64'h40) begin n_err++; $display("FAIL rd_fill_addr: got %h want 40", bus.l1i_lc_addr_out); end
    n_cmp++; if (bus.l1i_lc_value_out !== d1) begin n_err++; $display("FAIL rd_fill_value: got %h want %h", bus.l1i_lc_value_out, d1); end
    n_cmp++; if (bus.l1d_lc_valid_out !== 1'b0) begin n_err++; $display("FAIL rd_l1d_fill_quiet: got %b want 0", bus.l1d_lc_valid_out); end
    bus.l1i_lc_ready_in = 1'b1;
    @(negedge clk); bus.l1i_lc_ready_in = 1'b0; #1;
    n_cmp++; if (bus.l1i_lc_valid_out !== 1'b0) begin n_err++; $display("FAIL rd_fill_done: got %b want 0", bus.l1i_lc_valid_out); end
  endtask

  task automatic test_arbitration();
    do_reset();
    @(negedge clk);
    bus.l1i_req_valid_in = 1'b1; bus.l1i_req_addr_in = 64'h100;
    bus.l1d_req_valid_in = 1'b1; bus.l1d_req_addr_in = 64'h200; #1;
    n_cmp++; if (bus.l1d_req_ready_out !== 1'b1 || bus.l1i_req_ready_out !== 1'b0) begin n_err++; $display("FAIL arb_first: got d=%b i=%b want 1 0", bus.l1d_req_ready_out, bus.l1i_req_ready_out); end
    @(negedge clk); bus.l1d_req_valid_in = 1'b0; bus.mem_req_ready_in = 1'b1; #1;
    n_cmp++; if (bus.mem_req_addr_out !== 64'h200) begin n_err++; $display("FAIL arb_mem_addr1: got %h want 200", bus.mem_req_addr_out); end
    n_cmp++; if (bus.l1i_req_ready_out !== 1'b0) begin n_err++; $display("FAIL arb_busy_ready: got %b want 0", bus.l1i_req_ready_out); end
    @(negedge clk); bus.mem_req_ready_in = 1'b0; bus.mem_resp_valid_in = 1'b1; bus.mem_resp_data_in = rand_line();
    @(negedge clk); bus.mem_resp_valid_in = 1'b0; bus.l1d_lc_ready_in = 1'b1; #1;
    n_cmp++; if (bus.l1d_lc_valid_out !== 1'b1 || bus.l1d_lc_addr_out !== 64'h200) begin n_err++; $display("FAIL arb_fill1: got v=%b a=%h want 1 200", bus.l1d_lc_valid_out, bus.l1d_lc_addr_out); end
    @(negedge clk); bus.l1d_lc_ready_in = 1'b0; #1;
    n_cmp++; if (bus.l1i_req_ready_out !== 1'b1) begin n_err++; $display("FAIL arb_second: got %b want 1", bus.l1i_req_ready_out); end
    @(negedge clk); bus.l1i_req_valid_in = 1'b0; #1;
    n_cmp++; if (bus.mem_req_valid_out !== 1'b1 || bus.mem_req_addr_out !== 64'h100) begin n_err++; $display("FAIL arb_mem_addr2: got v=%b a=%h want 1 100", bus.mem_req_valid_out, bus.mem_req_addr_out); end
  endtask

  task automatic test_writeback();
    logic [DW-1:0] w;
    w = rand_line();
    do_reset();
    @(negedge clk);
    bus.l1d_req_valid_in = 1'b1; bus.l1d_req_addr_in = 64'h1C0; bus.l1d_req_we_in = 1'b1; bus.l1d_req_data_in = w;
    @(negedge clk); bus.l1d_req_valid_in = 1'b0; bus.l1d_req_we_in = 1'b0; bus.l1d_req_data_in = '0; bus.mem_req_ready_in = 1'b1; #1;
    n_cmp++; if (bus.mem_req_we_out !== 1'b1) begin n_err++; $display("FAIL wb_we: got %b want 1", bus.mem_req_we_out); end
    n_cmp++; if (bus.mem_req_data_out !== w) begin n_err++; $display("FAIL wb_data: got %h want %h", bus.mem_req_data_out, w); end
    n_cmp++; if (bus.mem_req_addr_out !== 64'h1C0) begin n_err++; $display("FAIL wb_addr: got %h want 1c0", bus.mem_req_addr_out); end
    @(negedge clk); bus.mem_req_ready_in = 1'b0; bus.mem_resp_valid_in = 1'b1;
    @(negedge clk); bus.mem_resp_valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++; if (bus.l1d_lc_valid_out !== 1'b0) begin n_err++; $display("FAIL wb_no_fill: got %b want 0", bus.l1d_lc_valid_out); end
      @(negedge clk);
    end
    bus.l1i_req_valid_in = 1'b1; #1;
    n_cmp++; if (bus.l1i_req_ready_out !== 1'b1) begin n_err++; $display("FAIL wb_back_idle: got %b want 1", bus.l1i_req_ready_out); end
    bus.l1i_req_valid_in = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = {$urandom, $urandom}; d = rand_line();
    do_reset();
    @(negedge clk); bus.l1i_req_valid_in = 1'b1; bus.l1i_req_addr_in = a;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); bus.l1d_req_valid_in = 1'b1; #1;
      n_cmp++; if (bus.mem_req_valid_out !== 1'b1 || bus.mem_req_addr_out !== (a & ALIGN) || bus.mem_req_we_out !== 1'b0) begin n_err++; $display("FAIL bp_mem_stall: got v=%b a=%h we=%b want 1 %h 0", bus.mem_req_valid_out, bus.mem_req_addr_out, bus.mem_req_we_out, a & ALIGN); end
      n_cmp++; if (bus.l1i_req_ready_out !== 1'b0 || bus.l1d_req_ready_out !== 1'b0) begin n_err++; $display("FAIL bp_ready_mem: got i=%b d=%b want 0 0", bus.l1i_req_ready_out, bus.l1d_req_ready_out); end
    end
    @(negedge clk); bus.mem_req_ready_in = 1'b1;
    @(negedge clk); bus.mem_req_ready_in = 1'b0; bus.mem_resp_valid_in = 1'b1; bus.mem_resp_data_in = d;
    @(negedge clk); bus.mem_resp_valid_in = 1'b0; bus.mem_resp_data_in = '0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_cmp++; if (bus.l1i_lc_valid_out !== 1'b1 || bus.l1i_lc_addr_out !== (a & ALIGN) || bus.l1i_lc_value_out !== d) begin n_err++; $display("FAIL bp_fill_stall: got v=%b a=%h want 1 %h", bus.l1i_lc_valid_out, bus.l1i_lc_addr_out, a & ALIGN); end
      n_cmp++; if (bus.l1i_req_ready_out !== 1'b0 || bus.l1d_req_ready_out !== 1'b0 || bus.l1d_lc_valid_out !== 1'b0) begin n_err++; $display("FAIL bp_ready_fill: got i=%b d=%b dlc=%b want 0 0 0", bus.l1i_req_ready_out, bus.l1d_req_ready_out, bus.l1d_lc_valid_out); end
    end
    @(negedge clk); bus.l1i_req_valid_in = 1'b0; bus.l1d_req_valid_in = 1'b0; bus.l1i_lc_ready_in = 1'b1;
    @(negedge clk); bus.l1i_lc_ready_in = 1'b0; #1;
    n_cmp++; if (bus.l1i_lc_valid_out !== 1'b0) begin n_err++; $display("FAIL bp_fill_done: got %b want 0", bus.l1i_lc_valid_out); end
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] d;
    d = rand_line();
    do_reset();
    @(negedge clk); bus.l1i_req_valid_in = 1'b1; bus.l1i_req_addr_in = 64'h1234;
    @(negedge clk); bus.l1i_req_valid_in = 1'b0; bus.mem_req_ready_in = 1'b1;
    @(negedge clk); bus.mem_req_ready_in = 1'b0; rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1; bus.mem_resp_valid_in = 1'b1; bus.mem_resp_data_in = rand_line(); #1;
    n_cmp++; if (bus.mem_req_valid_out !== 1'b0 || bus.l1i_lc_valid_out !== 1'b0 || bus.l1d_lc_valid_out !== 1'b0) begin n_err++; $display("FAIL ab_valids: got m=%b i=%b d=%b want 0 0 0", bus.mem_req_valid_out, bus.l1i_lc_valid_out, bus.l1d_lc_valid_out); end
    n_cmp++; if (bus.mem_req_addr_out !== '0 || bus.l1i_lc_addr_out !== '0 || bus.mem_req_we_out !== 1'b0) begin n_err++; $display("FAIL ab_fields: got a=%h we=%b want 0 0", bus.mem_req_addr_out, bus.mem_req_we_out); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); bus.mem_resp_valid_in = 1'b0; #1;
      n_cmp++; if (bus.mem_req_valid_out !== 1'b0 || bus.l1i_lc_valid_out !== 1'b0) begin n_err++; $display("FAIL ab_quiet: got m=%b i=%b want 0 0", bus.mem_req_valid_out, bus.l1i_lc_valid_out); end
    end
    @(negedge clk); bus.l1d_req_valid_in = 1'b1; bus.l1d_req_addr_in = 64'h85; #1;
    n_cmp++; if (bus.l1d_req_ready_out !== 1'b1) begin n_err++; $display("FAIL ab_next_ready: got %b want 1", bus.l1d_req_ready_out); end
    @(negedge clk); bus.l1d_req_valid_in = 1'b0; bus.mem_req_ready_in = 1'b1; #1;
    n_cmp++; if (bus.mem_req_addr_out !== 64'h80) begin n_err++; $display("FAIL ab_next_addr: got %h want 80", bus.mem_req_addr_out); end
    @(negedge clk); bus.mem_req_ready_in = 1'b0; bus.mem_resp_valid_in = 1'b1; bus.mem_resp_data_in = d;
    @(negedge clk); bus.mem_resp_valid_in = 1'b0; bus.l1d_lc_ready_in = 1'b1; #1;
    n_cmp++; if (bus.l1d_lc_valid_out !== 1'b1 || bus.l1d_lc_value_out !== d) begin n_err++; $display("FAIL ab_next_fill: got v=%b val=%h want 1 %h", bus.l1d_lc_valid_out, bus.l1d_lc_value_out, d); end
    @(negedge clk); bus.l1d_lc_ready_in = 1'b0;
  endtask

  task automatic test_back_to_back();
    int            acc[$];
    logic [AW-1:0] fills[$];
    do_reset();
    @(negedge clk);
    bus.l1i_req_valid_in = 1'b1; bus.l1i_req_addr_in = 64'h0; bus.mem_req_ready_in = 1'b1;
    bus.mem_resp_valid_in = 1'b1; bus.mem_resp_data_in = rand_line(); bus.l1i_lc_ready_in = 1'b1;
    for (int cyc = 0; cyc < 20 && fills.size() < 2; cyc++) begin
      #1;
      if (bus.l1i_req_valid_in && bus.l1i_req_ready_out) acc.push_back(cyc);
      if (bus.l1i_lc_valid_out) fills.push_back(bus.l1i_lc_addr_out);
      @(negedge clk);
      if (acc.size() == 1) bus.l1i_req_addr_in = 64'h40;
      if (acc.size() >= 2) bus.l1i_req_valid_in = 1'b0;
    end
    idle_inputs();
    n_cmp++; if (acc.size() != 2) begin n_err++; $display("FAIL b2b_accepts: got %0d want 2", acc.size()); end
    else begin
      n_cmp++; if (acc[1] - acc[0] != 4) begin n_err++; $display("FAIL b2b_spacing: got %0d want 4", acc[1] - acc[0]); end
    end
    n_cmp++; if (fills.size() != 2) begin n_err++; $display("FAIL b2b_fills: got %0d want 2", fills.size()); end
    else begin
      n_cmp++; if (fills[0] !== 64'h0 || fills[1] !== 64'h40) begin n_err++; $display("FAIL b2b_order: got %h,%h want 0,40", fills[0], fills[1]); end
    end
  endtask

  // Reference model: each source keeps a pending request until granted; contention
  // alternates winners, with L1D first after reset.
  task automatic test_random();
    logic          pend_i, pend_d, last_d, win_d, e_we, we_d;
    logic [AW-1:0] a_i, a_d, e_addr;
    logic [DW-1:0] wd_d, e_wdata, resp;
    int            d;
    do_reset();
    pend_i = 1'b0; pend_d = 1'b0; last_d = 1'b0;
    a_i = '0; a_d = '0; we_d = 1'b0; wd_d = '0;
    for (int t = 0; t < 40; t++) begin
      if (!pend_i && $urandom_range(0, 1) == 1) begin pend_i = 1'b1; a_i = {$urandom, $urandom}; end
      if (!pend_d && ($urandom_range(0, 1) == 1 || !pend_i)) begin
        pend_d = 1'b1; a_d = {$urandom, $urandom}; we_d = 1'($urandom_range(0, 1)); wd_d = rand_line();
      end
      win_d = pend_d && (!pend_i || !last_d);
      @(negedge clk);
      idle_inputs();
      bus.l1i_req_valid_in = pend_i; bus.l1i_req_addr_in = a_i;
      bus.l1d_req_valid_in = pend_d; bus.l1d_req_addr_in = a_d; bus.l1d_req_we_in = we_d; bus.l1d_req_data_in = wd_d;
      bus.mem_resp_valid_in = ($urandom_range(0, 3) == 0); bus.mem_resp_data_in = rand_line();
      #1;
      n_cmp++; if (bus.l1d_req_ready_out !== win_d || bus.l1i_req_ready_out !== !win_d) begin n_err++; $display("FAIL rnd_grant t=%0d: got d=%b i=%b want d=%b", t, bus.l1d_req_ready_out, bus.l1i_req_ready_out, win_d); end
      e_addr = (win_d ? a_d : a_i) & ALIGN; e_we = win_d && we_d; e_wdata = wd_d;
      last_d = win_d;
      if (win_d) pend_d = 1'b0; else pend_i = 1'b0;
      d = $urandom_range(0, 3);
      for (int k = 0; k <= d; k++) begin
        @(negedge clk);
        bus.l1i_req_valid_in = pend_i; bus.l1d_req_valid_in = pend_d;
        bus.mem_req_ready_in = (k == d); bus.mem_resp_valid_in = ($urandom_range(0, 1) == 1); #1;
        n_cmp++; if (bus.mem_req_valid_out !== 1'b1 || bus.mem_req_addr_out !== e_addr || bus.mem_req_we_out !== e_we || (e_we && bus.mem_req_data_out !== e_wdata)) begin n_err++; $display("FAIL rnd_mem t=%0d: got v=%b a=%h we=%b want 1 %h %b", t, bus.mem_req_valid_out, bus.mem_req_addr_out, bus.mem_req_we_out, e_addr, e_we); end
        n_cmp++; if (bus.l1i_req_ready_out !== 1'b0 || bus.l1d_req_ready_out !== 1'b0) begin n_err++; $display("FAIL rnd_busy t=%0d: got i=%b d=%b want 0 0", t, bus.l1i_req_ready_out, bus.l1d_req_ready_out); end
      end
      d = $urandom_range(0, 3); resp = rand_line();
      for (int k = 0; k <= d; k++) begin
        @(negedge clk);
        bus.mem_req_ready_in = 1'b0; bus.mem_resp_valid_in = (k == d); bus.mem_resp_data_in = resp; #1;
        n_cmp++; if (bus.mem_req_valid_out !== 1'b0 || bus.l1i_lc_valid_out !== 1'b0 || bus.l1d_lc_valid_out !== 1'b0) begin n_err++; $display("FAIL rnd_wait t=%0d: got m=%b i=%b d=%b want 0 0 0", t, bus.mem_req_valid_out, bus.l1i_lc_valid_out, bus.l1d_lc_valid_out); end
      end
      if (!e_we) begin
        d = $urandom_range(0, 3);
        for (int k = 0; k <= d; k++) begin
          @(negedge clk);
          bus.mem_resp_valid_in = ($urandom_range(0, 1) == 1); bus.mem_resp_data_in = rand_line();
          bus.l1i_lc_ready_in = !win_d && (k == d); bus.l1d_lc_ready_in = win_d && (k == d); #1;
          if (win_d) begin
            n_cmp++; if (bus.l1d_lc_valid_out !== 1'b1 || bus.l1i_lc_valid_out !== 1'b0 || bus.l1d_lc_addr_out !== e_addr || bus.l1d_lc_value_out !== resp) begin n_err++; $display("FAIL rnd_fill_d t=%0d: got v=%b iv=%b a=%h want 1 0 %h", t, bus.l1d_lc_valid_out, bus.l1i_lc_valid_out, bus.l1d_lc_addr_out, e_addr); end
          end else begin
            n_cmp++; if (bus.l1i_lc_valid_out !== 1'b1 || bus.l1d_lc_valid_out !== 1'b0 || bus.l1i_lc_addr_out !== e_addr || bus.l1i_lc_value_out !== resp) begin n_err++; $display("FAIL rnd_fill_i t=%0d: got v=%b dv=%b a=%h want 1 0 %h", t, bus.l1i_lc_valid_out, bus.l1d_lc_valid_out, bus.l1i_lc_addr_out, e_addr); end
          end
        end
      end
    end
    @(negedge clk); idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_l1i_read();
    test_arbitration();
    test_writeback();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/lc_arbiter.md
LC_ARBITER -- requirements
Module: lc_arbiter

Interface
REQ-001 SHALL have parameters: CACHE_LINE_BYTES, default 64, line size in bytes; ADDR_WIDTH, default 64, address width.
REQ-002 SHALL have port clk_in  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_N_in  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports l1i_req_valid_in  input  1 / l1i_req_ready_out  output  1 / l1i_req_addr_in  input  64: L1I miss (read) request.
REQ-005 SHALL have ports l1i_lc_valid_out  output  1 / l1i_lc_ready_in  input  1 / l1i_lc_addr_out  output  64 / l1i_lc_value_out  output  512: line fill to L1I.
REQ-006 SHALL have ports l1d_req_valid_in  input  1 / l1d_req_ready_out  output  1 / l1d_req_addr_in  input  64 / l1d_req_we_in  input  1 / l1d_req_data_in  input  512: L1D read miss or writeback.
REQ-007 SHALL have ports l1d_lc_valid_out  output  1 / l1d_lc_ready_in  input  1 / l1d_lc_addr_out  output  64 / l1d_lc_value_out  output  512: line fill to L1D.
REQ-008 SHALL have ports mem_req_valid_out  output  1 / mem_req_ready_in  input  1 / mem_req_addr_out  output  64 / mem_req_we_out  output  1 / mem_req_data_out  output  512: backing-memory request.
REQ-009 SHALL have ports mem_resp_valid_in  input  1 / mem_resp_data_in  input  512: backing-memory response (read data, or write ack).

Function
REQ-010 SHALL implement FSM states IDLE, MEM_REQ, MEM_WAIT, RESP; exactly one transaction outstanding.
REQ-011 IDLE: req_ready_out SHALL be 1 only for the source selected this cycle; a request SHALL be accepted on valid&&ready.
REQ-012 Arbitration SHALL be round-robin: when both valid, the source not granted last SHALL win; after reset L1D SHALL have priority.
REQ-013 On accept SHALL latch source, we, data and addr with bits [5:0] forced to 0 (line-aligned); IDLE->MEM_REQ.
REQ-014 MEM_REQ: mem_req_valid_out=1 with latched fields, held stable until mem_req_ready_in; on handshake ->MEM_WAIT.
REQ-015 MEM_WAIT: on mem_resp_valid_in SHALL latch mem_resp_data_in; read ->RESP; write ->IDLE with no fill issued.
REQ-016 RESP: selected source's lc_valid_out=1, lc_addr_out=latched aligned addr, lc_value_out=latched data, held stable until that lc_ready_in; on handshake ->IDLE.
REQ-017 The non-selected fill port SHALL keep lc_valid_out=0 at all times.
REQ-018 mem_resp_valid_in outside MEM_WAIT SHALL be ignored (no state change).
REQ-019 Minimum read latency, all handshakes immediate: accept cycle N, mem_req_valid at N+1, resp at N+2, fill valid at N+3; next accept no earlier than N+4.
REQ-020 req_ready_out SHALL be 0 in every state other than IDLE.

Reset
REQ-021 While rst_N_in=0 at a clock edge: state->IDLE, all valid/ready outputs 0, all addr/data/we outputs 0, round-robin pointer -> L1D priority.
REQ-022 Reset asserted mid-transaction SHALL abort it: no fill or memory request issued afterwards; late mem_resp_valid_in ignored.

Verification
REQ-023 L1I read addr 0x0000_0000_0000_0047, mem responds line D1 after 3 cycles -> mem_req_addr_out=0x40, we=0; l1i_lc_valid_out with addr 0x40, value D1; L1D fill never valid.
REQ-024 L1I and L1D both valid same cycle after reset (addrs 0x100, 0x200) -> L1D granted first, mem addr 0x200; L1I granted on next IDLE, mem addr 0x100.
REQ-025 L1D writeback addr 0x1C0, data W -> mem_req_we_out=1, data W; after mem_resp_valid_in, back to IDLE, l1d_lc_valid_out never asserted.
REQ-026 mem_req_ready_in held 0 for 5 cycles, l1i_lc_ready_in held 0 for 4 cycles -> mem request and fill outputs stable and valid throughout; req_ready_out stays 0.
REQ-027 rst_N_in=0 for one cycle while in MEM_WAIT, then spurious mem_resp_valid_in -> all outputs 0 after reset, no fill issued, next request serviced normally.
REQ-028 All handshakes immediate, back-to-back L1I reads 0x0 and 0x40 -> accepts exactly 4 cycles apart, fills in order.
